fila_arbiter: RTL and testbench

//  Sequencer and arbiter for the 8-entry fila. Two producers share fila's enqueue port; one consumer drains it.

---
 rtl/fila_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fila_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fila_arbiter.sv
// fila_arbiter: sequencer/arbiter in front of the 8-entry fila.
// Two producers share the enqueue port (round-robin). One consumer drains it.
// Every fila command is issued from IDLE only, so fila always sees it in wait_s.
// Occupancy is tracked locally; fila_len is only used by the optional checker.
// Optional feature: define FILA_CHECK_EN to enable the sticky len_err check.
module fila_arbiter #(
   parameter int DEPTH    = 8,
   parameter int DEQ_LAT  = 2,
   parameter int DEQ_BUSY = 4
) (
   input  logic       clk_10KHz,
   input  logic       reset,
   input  logic [1:0] prod_req,
   input  logic [7:0] prod_data0,
   input  logic [7:0] prod_data1,
   output logic [1:0] prod_ack,
   input  logic       cons_req,
   output logic       cons_valid,
   output logic [7:0] cons_data,
   output logic [7:0] fila_data,
   output logic       fila_enq,
   output logic       fila_deq,
   input  logic [7:0] fila_len,
   input  logic [7:0] fila_dout,
   output logic [3:0] occ,
   output logic       full,
   output logic       empty,
   output logic       len_err
);

   typedef enum logic [1:0] {IDLE, ENQ, DEQ} state_t;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_cnt, w_cnt_nxt;
   logic [3:0] r_occ, w_occ_nxt;
   logic       r_rr, w_rr_nxt;
   logic       r_last_enq, w_last_enq_nxt;   // last_op: 1 = ENQ, 0 = DEQ
   logic [7:0] r_fila_data, w_fila_data_nxt;
   logic [7:0] r_cons_data, w_cons_data_nxt;
   logic       r_fila_enq, w_enq_nxt;
   logic       r_fila_deq, w_deq_nxt;
   logic [1:0] r_ack, w_ack_nxt;
   logic       r_cons_valid, w_valid_nxt;
   logic       r_full, w_full_nxt;
   logic       r_empty, w_empty_nxt;
   logic       w_enq_ok, w_deq_ok, w_sel;

   // State and all registered outputs; reset also clears an in-flight dequeue
   always_ff @(posedge clk_10KHz) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_occ        <= '0;
         r_rr         <= 1'b0;
         r_last_enq   <= 1'b0;
         r_fila_data  <= '0;
         r_cons_data  <= '0;
         r_fila_enq   <= 1'b0;
         r_fila_deq   <= 1'b0;
         r_ack        <= '0;
         r_cons_valid <= 1'b0;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_occ        <= w_occ_nxt;
         r_rr         <= w_rr_nxt;
         r_last_enq   <= w_last_enq_nxt;
         r_fila_data  <= w_fila_data_nxt;
         r_cons_data  <= w_cons_data_nxt;
         r_fila_enq   <= w_enq_nxt;
         r_fila_deq   <= w_deq_nxt;
         r_ack        <= w_ack_nxt;
         r_cons_valid <= w_valid_nxt;
         r_full       <= w_full_nxt;
         r_empty      <= w_empty_nxt;
      end
   end

   // Next-state: arbitrate in IDLE, count out the fila dequeue latency in DEQ
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_occ_nxt       = r_occ;
      w_rr_nxt        = r_rr;
      w_last_enq_nxt  = r_last_enq;
      w_fila_data_nxt = r_fila_data;
      w_cons_data_nxt = r_cons_data;
      w_enq_nxt       = 1'b0;
      w_deq_nxt       = 1'b0;
      w_ack_nxt       = '0;
      w_valid_nxt     = 1'b0;
      w_sel           = 1'b0;
      w_enq_ok        = (|prod_req) && !r_full;
      w_deq_ok        = cons_req && !r_empty;
      case (r_state)
         IDLE: begin
            // With both ops ready, do the one opposite to last_op
            if (w_enq_ok && (!w_deq_ok || !r_last_enq)) begin
               w_sel           = (prod_req == 2'b11) ? r_rr : prod_req[1];
               w_fila_data_nxt = w_sel ? prod_data1 : prod_data0;
               w_enq_nxt       = 1'b1;
               w_ack_nxt[w_sel] = 1'b1;
               w_rr_nxt        = ~w_sel;
               w_state_nxt     = ENQ;
            end else if (w_deq_ok) begin
               w_deq_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = DEQ;
            end
         end
         ENQ: begin
            w_occ_nxt      = r_occ + 4'd1;
            w_last_enq_nxt = 1'b1;
            w_state_nxt    = IDLE;
         end
         DEQ: begin
            w_cnt_nxt = r_cnt + 3'd1;
            // fila data_out is valid at c2; capture it so cons_valid lands in c3
            if (r_cnt == 3'(DEQ_LAT)) begin
               w_cons_data_nxt = fila_dout;
               w_valid_nxt     = 1'b1;
               w_occ_nxt       = r_occ - 4'd1;
            end
            if (r_cnt == 3'(DEQ_BUSY - 1)) begin
               w_last_enq_nxt = 1'b0;
               w_state_nxt    = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_full_nxt  = (w_occ_nxt == 4'(DEPTH));
      w_empty_nxt = (w_occ_nxt == 4'd0);
   end

`ifdef FILA_CHECK_EN
   logic r_len_err, r_after_op;
   // Compare fila's (lagging) length only in IDLE cycles that follow an IDLE cycle
   always_ff @(posedge clk_10KHz) begin
      if (!reset) begin
         r_len_err  <= 1'b0;
         r_after_op <= 1'b0;
      end else begin
         r_after_op <= (r_state != IDLE);
         if (r_state == IDLE && !r_after_op && fila_len != {4'd0, r_occ})
            r_len_err <= 1'b1;
      end
   end
   assign len_err = r_len_err;
`else
   logic w_unused_len;
   assign w_unused_len = ^fila_len;
   assign len_err      = 1'b0;
`endif

   assign prod_ack   = r_ack;
   assign cons_valid = r_cons_valid;
   assign cons_data  = r_cons_data;
   assign fila_data  = r_fila_data;
   assign fila_enq   = r_fila_enq;
   assign fila_deq   = r_fila_deq;
   assign occ        = r_occ;
   assign full       = r_full;
   assign empty      = r_empty;

endmodule

// File: tb/tb_fila_arbiter.sv
// Bench for fila_arbiter: behavioural fila model plus scenario tasks and a
// randomized run scored against a queue-based reference of accepted bytes.
module tb_fila_arbiter;

   logic       clk_10KHz = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] prod_req = '0;
   logic [7:0] prod_data0 = '0, prod_data1 = '0;
   logic [1:0] prod_ack;
   logic       cons_req = 1'b0;
   logic       cons_valid;
   logic [7:0] cons_data, fila_data;
   logic       fila_enq, fila_deq;
   logic [7:0] fila_len = '0, fila_dout = '0;
   logic [3:0] occ;
   logic       full, empty, len_err;

   int n_cmp = 0;
   int n_err = 0;
   int len_bias = 0;

   fila_arbiter dut (
      .clk_10KHz(clk_10KHz), .reset(reset), .prod_req(prod_req),
      .prod_data0(prod_data0), .prod_data1(prod_data1), .prod_ack(prod_ack),
      .cons_req(cons_req), .cons_valid(cons_valid), .cons_data(cons_data),
      .fila_data(fila_data), .fila_enq(fila_enq), .fila_deq(fila_deq),
      .fila_len(fila_len), .fila_dout(fila_dout), .occ(occ), .full(full),
      .empty(empty), .len_err(len_err)
   );

   always #5 clk_10KHz = ~clk_10KHz;

   // fila model: FIFO, data_out valid two cycles after the dequeue cycle, len lags
   logic [7:0] fq[$];
   logic [7:0] stage = '0;
   always @(posedge clk_10KHz) begin
      if (!reset) begin
         fq.delete();
         stage     <= '0;
         fila_dout <= '0;
         fila_len  <= '0;
      end else begin
         if (fila_enq) fq.push_back(fila_data);
         if (fila_deq && fq.size() > 0) stage <= fq.pop_front();
         fila_dout <= stage;
         fila_len  <= 8'(fq.size() + len_bias);
      end
   end

   task automatic do_reset();
      prod_req = '0;
      cons_req = 1'b0;
      reset    = 1'b0;
      repeat (2) @(negedge clk_10KHz);
      reset = 1'b1;
   endtask

   task automatic enq_byte(input int p, input logic [7:0] d);
      bit got = 0;
      if (p == 0) prod_data0 = d; else prod_data1 = d;
      prod_req[p] = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk_10KHz);
         if (prod_ack[p]) got = 1;
      end
      prod_req[p] = 1'b0;
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL enq_byte: producer %0d got no ack in 20 cycles, required an ack", p);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk_10KHz);
      n_cmp++;
      if ({prod_ack, cons_valid, fila_enq, fila_deq, occ, full, empty, len_err} !== 12'b0000_0000_0010) begin
         n_err++;
         $display("FAIL reset_ctrl: got ack=%b v=%b enq=%b deq=%b occ=%0d full=%b empty=%b lerr=%b, required all 0 except empty=1",
                  prod_ack, cons_valid, fila_enq, fila_deq, occ, full, empty, len_err);
      end
      n_cmp++;
      if ({cons_data, fila_data} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_data: got cons_data=%h fila_data=%h, required 00 00", cons_data, fila_data);
      end
      reset = 1'b1;
   endtask

   task automatic test_single_enq();
      do_reset();
      prod_data0 = 8'hA5;
      prod_req   = 2'b01;
      @(negedge clk_10KHz);
      n_cmp++;
      if (prod_ack !== 2'b01 || fila_enq !== 1'b1 || fila_data !== 8'hA5) begin
         n_err++;
         $display("FAIL single_enq_d1: got ack=%b enq=%b data=%h, required 01 1 a5", prod_ack, fila_enq, fila_data);
      end
      prod_req = 2'b00;
      @(negedge clk_10KHz);
      n_cmp++;
      if (occ !== 4'd1 || prod_ack !== 2'b00 || fila_enq !== 1'b0 || len_err !== 1'b0 || empty !== 1'b0) begin
         n_err++;
         $display("FAIL single_enq_d2: got occ=%0d ack=%b enq=%b lerr=%b empty=%b, required 1 00 0 0 0",
                  occ, prod_ack, fila_enq, len_err, empty);
      end
   endtask

   task automatic test_round_robin_fill();
      int nack = 0, last_t = -1;
      do_reset();
      prod_data0 = 8'h11;
      prod_data1 = 8'h22;
      prod_req   = 2'b11;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk_10KHz);
         if (prod_ack != 2'b00) begin
            n_cmp++;
            if (prod_ack !== (nack % 2 == 0 ? 2'b01 : 2'b10)) begin
               n_err++;
               $display("FAIL rr_order: grant %0d got ack=%b, required %b", nack, prod_ack, (nack % 2 == 0 ? 2'b01 : 2'b10));
            end
            if (last_t >= 0) begin
               n_cmp++;
               if (t - last_t != 2) begin
                  n_err++;
                  $display("FAIL rr_gap: grant %0d gap %0d cycles, required 2", nack, t - last_t);
               end
            end
            last_t = t;
            nack++;
         end
      end
      prod_req = 2'b00;
      n_cmp++;
      if (nack != 8 || occ !== 4'd8 || full !== 1'b1) begin
         n_err++;
         $display("FAIL rr_full: got acks=%0d occ=%0d full=%b, required 8 8 1", nack, occ, full);
      end
   endtask

   task automatic test_drain();
      int nv = 0, last_t = -1;
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
      do_reset();
      for (int k = 0; k < 3; k++) enq_byte(0, exp_d[k]);
      cons_req = 1'b1;
      for (int t = 0; t < 40 && nv < 3; t++) begin
         @(negedge clk_10KHz);
         if (cons_valid) begin
            n_cmp++;
            if (cons_data !== exp_d[nv]) begin
               n_err++;
               $display("FAIL drain_data: pulse %0d got %h, required %h", nv, cons_data, exp_d[nv]);
            end
            if (last_t >= 0) begin
               n_cmp++;
               if (t - last_t != 5) begin
                  n_err++;
                  $display("FAIL drain_gap: pulse %0d gap %0d cycles, required 5", nv, t - last_t);
               end
            end
            last_t = t;
            nv++;
         end
      end
      n_cmp++;
      if (nv != 3) begin
         n_err++;
         $display("FAIL drain_count: got %0d pulses, required 3", nv);
      end
      for (int t = 0; t < 10; t++) begin
         @(negedge clk_10KHz);
         n_cmp++;
         if (fila_deq !== 1'b0 || empty !== 1'b1 || cons_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty: got deq=%b empty=%b valid=%b, required 0 1 0", fila_deq, empty, cons_valid);
         end
      end
      cons_req = 1'b0;
   endtask

   task automatic test_interleave();
      int nops = 0;
      do_reset();
      for (int k = 0; k < 4; k++) enq_byte(0, 8'(k + 1));
      prod_data0 = 8'h5A;
      prod_req   = 2'b01;
      cons_req   = 1'b1;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk_10KHz);
         n_cmp++;
         if (fila_enq && fila_deq) begin
            n_err++;
            $display("FAIL interleave_both: got enq=1 deq=1, required not both");
         end
         if (fila_enq || fila_deq) begin
            n_cmp++;
            // first op must be DEQ (last op was ENQ), then alternate
            if (fila_deq !== (nops % 2 == 0)) begin
               n_err++;
               $display("FAIL interleave_order: op %0d got deq=%b, required %b", nops, fila_deq, (nops % 2 == 0));
            end
            nops++;
         end
      end
      prod_req = 2'b00;
      cons_req = 1'b0;
      n_cmp++;
      if (nops < 6) begin
         n_err++;
         $display("FAIL interleave_count: got %0d ops, required at least 6", nops);
      end
   endtask

   task automatic test_reset_mid_deq();
      bit seen = 0;
      do_reset();
      enq_byte(1, 8'h77);
      cons_req = 1'b1;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk_10KHz);
         if (fila_deq) seen = 1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL rst_deq_start: got no fila_deq in 10 cycles, required one");
      end
      @(negedge clk_10KHz);   // c1
      reset = 1'b0;
      @(negedge clk_10KHz);
      n_cmp++;
      if (occ !== 4'd0 || empty !== 1'b1 || cons_valid !== 1'b0 || fila_enq !== 1'b0 ||
          fila_deq !== 1'b0 || fila_data !== 8'h00) begin
         n_err++;
         $display("FAIL rst_deq_state: got occ=%0d empty=%b valid=%b enq=%b deq=%b data=%h, required 0 1 0 0 0 00",
                  occ, empty, cons_valid, fila_enq, fila_deq, fila_data);
      end
      reset    = 1'b1;
      cons_req = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk_10KHz);
         n_cmp++;
         if (cons_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_deq_valid: got cons_valid=1 after abort, required 0");
         end
      end
      // back in IDLE: a fresh enqueue is acked straight away
      prod_data0 = 8'h3C;
      prod_req   = 2'b01;
      @(negedge clk_10KHz);
      n_cmp++;
      if (prod_ack !== 2'b01) begin
         n_err++;
         $display("FAIL rst_deq_idle: got ack=%b one cycle after request, required 01", prod_ack);
      end
      prod_req = 2'b00;
   endtask

   task automatic test_len_check();
      do_reset();
      enq_byte(0, 8'h42);
      len_bias = 1;
      repeat (5) @(negedge clk_10KHz);
`ifdef FILA_CHECK_EN
      n_cmp++;
      if (len_err !== 1'b1) begin
         n_err++;
         $display("FAIL len_err_set: got %b, required 1", len_err);
      end
      len_bias = 0;
      repeat (5) @(negedge clk_10KHz);
      n_cmp++;
      if (len_err !== 1'b1) begin
         n_err++;
         $display("FAIL len_err_sticky: got %b, required 1", len_err);
      end
`else
      n_cmp++;
      if (len_err !== 1'b0) begin
         n_err++;
         $display("FAIL len_err_off: got %b, required 0", len_err);
      end
      len_bias = 0;
`endif
      do_reset();
      @(negedge clk_10KHz);
      n_cmp++;
      if (len_err !== 1'b0) begin
         n_err++;
         $display("FAIL len_err_reset: got %b, required 0", len_err);
      end
   endtask

   // Reference: accepted bytes leave in acceptance order; occupancy is
   // acks minus valids; acked producer must have been requesting.
   task automatic test_random();
      logic [7:0] sb[$];
      logic [7:0] exp_b;
      int cnt = 0;
      do_reset();
      for (int t = 0; t < 400; t++) begin
         @(negedge clk_10KHz);
         if (cons_valid) begin
            exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++;
            if (cons_data !== exp_b) begin
               n_err++;
               $display("FAIL rand_data: t=%0d got %h, required %h", t, cons_data, exp_b);
            end
            cnt--;
            cons_req = 1'b0;
         end
         n_cmp++;
         if (occ !== 4'(cnt) || full !== (cnt == 8) || empty !== (cnt == 0) || (fila_enq && fila_deq)) begin
            n_err++;
            $display("FAIL rand_occ: t=%0d got occ=%0d full=%b empty=%b enq&deq=%b, required occ=%0d full=%b empty=%b 0",
                     t, occ, full, empty, fila_enq && fila_deq, cnt, cnt == 8, cnt == 0);
         end
         if (prod_ack != 2'b00) begin
            n_cmp++;
            if (prod_ack == 2'b11 || (prod_ack & ~prod_req) != 2'b00 || cnt >= 8) begin
               n_err++;
               $display("FAIL rand_ack: t=%0d got ack=%b req=%b count=%0d, required one-hot requested ack below full",
                        t, prod_ack, prod_req, cnt);
            end
            sb.push_back(prod_ack[1] ? prod_data1 : prod_data0);
            cnt++;
            prod_req = prod_req & ~prod_ack;
         end
         for (int p = 0; p < 2; p++) begin
            if (!prod_req[p] && $urandom_range(2) == 0) begin
               if (p == 0) prod_data0 = 8'($urandom); else prod_data1 = 8'($urandom);
               prod_req[p] = 1'b1;
            end
         end
         if (!cons_req && $urandom_range(3) == 0) cons_req = 1'b1;
      end
      prod_req = 2'b00;
      cons_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_enq();
      test_round_robin_fill();
      test_drain();
      test_interleave();
      test_reset_mid_deq();
      test_len_check();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
